uart_core_param: RTL

//  Parametrised full-duplex UART core: TX serialiser plus RX deserialiser with a receive FIFO.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_core_param_if.sv | 39 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_core_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and helpers for the parametrised UART core
package uart_pkg;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Callers zero-extend the data word, so the unused upper bits do not affect the result.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// rtl/uart_core_param_if.sv - bus-side and pin-side signal bundle of the UART core
interface uart_core_param_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] data_in_tx;
  logic              tx_en;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_start;
  logic              tx_done;
  logic              rx_in;
  logic              rx_en;
  logic              rd_en;
  logic [DATA_W-1:0] data_out_rx;
  logic              rx_busy;
  logic              rx_start;
  logic              rx_done;
  logic              rx_empty;
  logic [CW-1:0]     rx_count;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    output data_in_tx, tx_en, rx_in, rx_en, rd_en,
    input  tx_out, tx_busy, tx_start, tx_done, data_out_rx, rx_busy, rx_start, rx_done,
           rx_empty, rx_count, frame_err, parity_err, overrun
  );

  modport slave (
    input  data_in_tx, tx_en, rx_in, rx_en, rd_en,
    output tx_out, tx_busy, tx_start, tx_done, data_out_rx, rx_busy, rx_start, rx_done,
           rx_empty, rx_count, frame_err, parity_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - full-duplex UART core with RX FIFO; parity bit enabled by UART_PARITY_EN
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_core_param_if.slave     bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic             ODD       = 1'(PARITY_ODD);
  logic tx_par, parity_err_q;
`endif

  tx_state_t         tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [3:0]        tx_bit;
  logic              tx_stop, tx_out_q, tx_busy_q, tx_start_q, tx_done_q, tx_load;

  rx_state_t         rx_state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [3:0]        rx_bit;
  logic              rx_s1, rx_s2, rx_prev;
  logic              rx_busy_q, rx_start_q, rx_done_q, frame_err_q, overrun_q, fifo_full;

  // Back-to-back frames: a start strobe in the final stop cycle is taken without an idle gap.
  assign tx_load = bus.tx_en && ((tx_state == TX_IDLE) ||
                   (tx_state == TX_STOP && tx_cnt == BIT_LAST && tx_stop == LAST_STOP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_sh      <= '0;
      tx_bit     <= '0;
      tx_stop    <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_cnt     <= (tx_cnt == BIT_LAST) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: tx_cnt <= '0;
        TX_START: if (tx_cnt == BIT_LAST) begin
          tx_state <= TX_DATA;
          tx_out_q <= tx_sh[0];
          tx_bit   <= '0;
        end
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state <= TX_PARITY;
            tx_out_q <= tx_par;
`else
            tx_state <= TX_STOP;
            tx_out_q <= 1'b1;
            tx_stop  <= 1'b0;
`endif
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_sh    <= tx_sh >> 1;
            tx_out_q <= tx_sh[1];
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (tx_cnt == BIT_LAST) begin
          tx_state <= TX_STOP;
          tx_out_q <= 1'b1;
          tx_stop  <= 1'b0;
        end
`endif
        TX_STOP: begin
          if (tx_stop == LAST_STOP && tx_cnt == BIT_PRE) tx_done_q <= 1'b1;
          if (tx_cnt == BIT_LAST) begin
            if (tx_stop != LAST_STOP) begin
              tx_stop <= 1'b1;
            end else begin
              tx_state  <= TX_IDLE;
              tx_busy_q <= 1'b0;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
      if (tx_load) begin
        tx_state   <= TX_START;
        tx_sh      <= bus.data_in_tx;
        tx_cnt     <= '0;
        tx_out_q   <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_start_q <= 1'b1;
`ifdef UART_PARITY_EN
        tx_par     <= calc_parity(9'(bus.data_in_tx), ODD);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_sh       <= '0;
      rx_bit      <= '0;
      rx_busy_q   <= 1'b0;
      rx_start_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_s1      <= bus.rx_in;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_start_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_cnt     <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + 1'b1;
      // Reads clear the sticky flags; a fresh error in the same cycle still wins below.
      if (bus.rd_en) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      if (rx_done_q && fifo_full && !bus.rd_en) overrun_q <= 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2 && bus.rx_en) rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          if (rx_s2) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_state   <= RX_DATA;
            rx_start_q <= 1'b1;
            rx_busy_q  <= 1'b1;
            rx_bit     <= '0;
          end
        end
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
          if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state <= RX_PARITY;
`else
            rx_state <= RX_STOP;
`endif
          end else begin
            rx_bit <= rx_bit + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (rx_cnt == BIT_LAST) begin
          if (rx_s2 != calc_parity(9'(rx_sh), ODD)) parity_err_q <= 1'b1;
          rx_state <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_done_q <= 1'b1;
          rx_busy_q <= 1'b0;
          if (!rx_s2) frame_err_q <= 1'b1;
          rx_state  <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_done_q),
    .push_data (rx_sh),
    .pop       (bus.rd_en),
    .head      (bus.data_out_rx),
    .empty     (bus.rx_empty),
    .full      (fifo_full),
    .count     (bus.rx_count)
  );

  assign bus.tx_out    = tx_out_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.rx_start  = rx_start_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
